nco_chirp_seq: RTL and testbench

Multi-chirp NCO sequencer, the parametrised successor of the single-chirp NCO. It generates a train of 1 to 2^REP_WIDTH up- or down-chirps back to back, keeping phase continuous across chirp boundaries. Bandwidth limits scale with PHASE_WIDTH, and all config is latched at start. It feeds the phase-to-amplitude LUT stage of the chirp transmitter and is paced by the sample-tick strobe.

---
 rtl/nco_chirp_seq_if.sv | 34 +++
 rtl/nco_chirp_seq.sv | 174 +++++++++++++++++
 tb/tb_nco_chirp_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/nco_chirp_seq_if.sv
// Control, configuration and output bundle of the multi-chirp NCO sequencer.
// The sequencer attaches through the slave modport; the driving side uses master.
interface nco_chirp_seq_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int SF_WIDTH    = 4,
  parameter int REP_WIDTH   = 4
);
  logic                   i_start_n;
  logic                   i_abort_n;
  logic [SF_WIDTH-1:0]    i_SF;
  logic                   i_down;
  logic [REP_WIDTH-1:0]   i_num_sym;
  logic [1:0]             i_bw_config;
  logic [PHASE_WIDTH-1:0] i_init_phase_inc;
  logic [PHASE_WIDTH-1:0] i_slope;
  logic                   i_sample_tick_n;
  logic [PHASE_WIDTH-1:0] o_phase_acc;
  logic [PHASE_WIDTH-1:0] o_phase_inc;
  logic                   o_sym_start_n;
  logic                   o_busy;
  logic                   o_done_n;

  modport master (
    output i_start_n, i_abort_n, i_SF, i_down, i_num_sym, i_bw_config,
           i_init_phase_inc, i_slope, i_sample_tick_n,
    input  o_phase_acc, o_phase_inc, o_sym_start_n, o_busy, o_done_n
  );

  modport slave (
    input  i_start_n, i_abort_n, i_SF, i_down, i_num_sym, i_bw_config,
           i_init_phase_inc, i_slope, i_sample_tick_n,
    output o_phase_acc, o_phase_inc, o_sym_start_n, o_busy, o_done_n
  );
endinterface

// File: rtl/nco_chirp_seq.sv
// Multi-chirp NCO sequencer: phase-continuous train of up/down chirps,
// stepped on falling edges of the sample-tick strobe.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last values
// LOAD  | latch configuration, clear accumulator and counters
// RUN   | accumulate and sweep increment on each tick
// DONE  | one-cycle completion pulse on o_done_n
module nco_chirp_seq #(
  parameter int PHASE_WIDTH = 32,
  parameter int SF_WIDTH    = 4,
  parameter int SF_MIN      = 5,
  parameter int SF_MAX      = 12,
  parameter int REP_WIDTH   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  nco_chirp_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [PHASE_WIDTH:0]   FULL_SCALE = {1'b1, {PHASE_WIDTH{1'b0}}};
  localparam logic [PHASE_WIDTH-1:0] INC_80 = PHASE_WIDTH'(FULL_SCALE / 80);
  localparam logic [PHASE_WIDTH-1:0] INC_40 = PHASE_WIDTH'(FULL_SCALE / 40);
  localparam logic [PHASE_WIDTH-1:0] INC_20 = PHASE_WIDTH'(FULL_SCALE / 20);

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d, inc_q, inc_d;
  logic [PHASE_WIDTH-1:0] init_q, init_d, slope_q, slope_d, inc_max_q, inc_max_d;
  logic [SF_WIDTH-1:0]    sf_q, sf_d;
  logic                   down_q, down_d;
  logic [REP_WIDTH-1:0]   nsym_q, nsym_d, chirp_q, chirp_d;
  logic [SF_MAX-1:0]      scnt_q, scnt_d;
  logic                   sym_n_q, sym_n_d;
  logic                   tick_dly_q;

  logic                   tick;
  logic [SF_WIDTH-1:0]    sf_clamp;
  logic [PHASE_WIDTH-1:0] inc_max_sel;
  logic [PHASE_WIDTH:0]   up_sum;
  logic [PHASE_WIDTH-1:0] inc_step;
  logic [SF_MAX:0]        sym_len;
  logic                   sym_last;

  assign tick = tick_dly_q & ~bus.i_sample_tick_n;

  always_comb begin
    sf_clamp = bus.i_SF;
    if (bus.i_SF < SF_WIDTH'(SF_MIN))      sf_clamp = SF_WIDTH'(SF_MIN);
    else if (bus.i_SF > SF_WIDTH'(SF_MAX)) sf_clamp = SF_WIDTH'(SF_MAX);
  end

  always_comb begin
    inc_max_sel = INC_80;
    case (bus.i_bw_config)
      2'd1:    inc_max_sel = INC_40;
      2'd2:    inc_max_sel = INC_20;
      default: inc_max_sel = INC_80;
    endcase
  end

  // Up sweep needs the carry bit so the wrap compare sees the true sum.
  assign up_sum = {1'b0, inc_q} + {1'b0, slope_q};

  always_comb begin
    inc_step = inc_q;
    if (!down_q)
      inc_step = (up_sum >= {1'b0, inc_max_q}) ? PHASE_WIDTH'(up_sum - {1'b0, inc_max_q})
                                               : up_sum[PHASE_WIDTH-1:0];
    else
      inc_step = (inc_q >= slope_q) ? inc_q - slope_q : inc_q - slope_q + inc_max_q;
  end

  assign sym_len  = (SF_MAX+1)'(1) << sf_q;
  assign sym_last = ({1'b0, scnt_q} == sym_len - (SF_MAX+1)'(1));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    inc_d     = inc_q;
    init_d    = init_q;
    slope_d   = slope_q;
    inc_max_d = inc_max_q;
    sf_d      = sf_q;
    down_d    = down_q;
    nsym_d    = nsym_q;
    chirp_d   = chirp_q;
    scnt_d    = scnt_q;
    sym_n_d   = 1'b1;
    unique case (state_q)
      IDLE: if (!bus.i_start_n) state_d = LOAD;
      LOAD: begin
        if (!bus.i_abort_n) begin
          state_d = IDLE;
        end else begin
          sf_d      = sf_clamp;
          down_d    = bus.i_down;
          nsym_d    = bus.i_num_sym;
          inc_max_d = inc_max_sel;
          init_d    = bus.i_init_phase_inc;
          slope_d   = bus.i_slope;
          acc_d     = '0;
          inc_d     = bus.i_init_phase_inc;
          scnt_d    = '0;
          chirp_d   = '0;
          sym_n_d   = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (!bus.i_abort_n) begin
          state_d = IDLE;
        end else if (tick) begin
          acc_d = acc_q + inc_q;
          if (sym_last && chirp_q == nsym_q) begin
            inc_d   = inc_step;
            state_d = DONE;
          end else if (sym_last) begin
            // Chirp boundary: restart the sweep but keep the phase running.
            chirp_d = chirp_q + 1'b1;
            scnt_d  = '0;
            inc_d   = init_q;
            sym_n_d = 1'b0;
          end else begin
            inc_d  = inc_step;
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      inc_q      <= '0;
      init_q     <= '0;
      slope_q    <= '0;
      inc_max_q  <= '0;
      sf_q       <= '0;
      down_q     <= 1'b0;
      nsym_q     <= '0;
      chirp_q    <= '0;
      scnt_q     <= '0;
      sym_n_q    <= 1'b1;
      tick_dly_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      init_q     <= init_d;
      slope_q    <= slope_d;
      inc_max_q  <= inc_max_d;
      sf_q       <= sf_d;
      down_q     <= down_d;
      nsym_q     <= nsym_d;
      chirp_q    <= chirp_d;
      scnt_q     <= scnt_d;
      sym_n_q    <= sym_n_d;
      tick_dly_q <= bus.i_sample_tick_n;
    end
  end

  assign bus.o_phase_acc   = acc_q;
  assign bus.o_phase_inc   = inc_q;
  assign bus.o_sym_start_n = sym_n_q;
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_done_n      = (state_q != DONE);

endmodule

// File: tb/tb_nco_chirp_seq.sv
// Directed bench for nco_chirp_seq: a tick-level model of the chirp rules is
// compared every cycle, plus hand-computed literals that pin the model.
module tb_nco_chirp_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nco_chirp_seq_if #(.PHASE_WIDTH(32), .SF_WIDTH(4), .REP_WIDTH(4)) bus ();

  nco_chirp_seq #(.PHASE_WIDTH(32), .SF_WIDTH(4), .SF_MIN(5), .SF_MAX(12),
                  .REP_WIDTH(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int ticks_sent = 0;
  int done_cnt = 0;
  int done_at = -1;
  int sym_q[$];

  // Model: phase 0 idle, 1 load, 2 run, 3 done.
  int          m_ph;
  logic [31:0] m_acc, m_inc, m_init, m_slope, m_max;
  int          m_sf, m_nsym, m_chirp, m_scnt;
  logic        m_down, m_tdly, m_sym;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_acc = '0; m_inc = '0; m_tdly = 1'b1; m_sym = 1'b1;
  endtask

  function automatic logic [31:0] bw_max(input logic [1:0] bw);
    case (bw)
      2'd1:    return 32'h06666666;
      2'd2:    return 32'h0CCCCCCC;
      default: return 32'h03333333;
    endcase
  endfunction

  function automatic logic [31:0] swept(input logic [31:0] inc);
    logic [32:0] s;
    if (!m_down) begin
      s = {1'b0, inc} + {1'b0, m_slope};
      return (s >= {1'b0, m_max}) ? 32'(s - {1'b0, m_max}) : s[31:0];
    end
    return (inc >= m_slope) ? inc - m_slope : inc - m_slope + m_max;
  endfunction

  task automatic model_edge();
    logic tk;
    tk = m_tdly & ~bus.i_sample_tick_n;
    m_tdly = bus.i_sample_tick_n;
    m_sym = 1'b1;
    case (m_ph)
      0: if (!bus.i_start_n) m_ph = 1;
      1: if (!bus.i_abort_n) m_ph = 0;
         else begin
           m_sf = (int'(bus.i_SF) < 5) ? 5 : (int'(bus.i_SF) > 12) ? 12 : int'(bus.i_SF);
           m_down = bus.i_down; m_nsym = int'(bus.i_num_sym); m_max = bw_max(bus.i_bw_config);
           m_init = bus.i_init_phase_inc; m_slope = bus.i_slope;
           m_acc = '0; m_inc = m_init; m_scnt = 0; m_chirp = 0; m_sym = 1'b0; m_ph = 2;
         end
      2: if (!bus.i_abort_n) m_ph = 0;
         else if (tk) begin
           m_acc = m_acc + m_inc;
           if (m_scnt == (1 << m_sf) - 1 && m_chirp == m_nsym) begin
             m_inc = swept(m_inc); m_ph = 3;
           end else if (m_scnt == (1 << m_sf) - 1) begin
             m_chirp++; m_scnt = 0; m_inc = m_init; m_sym = 1'b0;
           end else begin
             m_inc = swept(m_inc); m_scnt++;
           end
         end
      default: m_ph = 0;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase_acc", bus.o_phase_acc, m_acc);
      chk("phase_inc", bus.o_phase_inc, m_inc);
      chk("busy", 32'(bus.o_busy), 32'(m_ph != 0));
      chk("sym_start_n", 32'(bus.o_sym_start_n), 32'(m_sym));
      chk("done_n", 32'(bus.o_done_n), 32'(m_ph != 3));
      if (!bus.o_done_n) begin done_cnt++; done_at = ticks_sent; end
      if (!bus.o_sym_start_n) sym_q.push_back(ticks_sent);
    end
  end

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic run_tick();
    bus.i_sample_tick_n = 1'b0; cycle(); ticks_sent++;
    bus.i_sample_tick_n = 1'b1; cycle();
  endtask

  task automatic setup(input logic [3:0] sf, input logic dn, input logic [3:0] ns,
                       input logic [1:0] bw, input logic [31:0] init, input logic [31:0] slope);
    bus.i_SF = sf; bus.i_down = dn; bus.i_num_sym = ns; bus.i_bw_config = bw;
    bus.i_init_phase_inc = init; bus.i_slope = slope;
  endtask

  task automatic start_seq();
    ticks_sent = 0; sym_q.delete();
    bus.i_start_n = 1'b0; cycle();
    bus.i_start_n = 1'b1; cycle();
  endtask

  task automatic abort_seq();
    bus.i_abort_n = 1'b0; cycle();
    bus.i_abort_n = 1'b1; cycle();
  endtask

  task automatic run_until_done(input int max_ticks, input string nm, input int exp_at);
    int d0 = done_cnt;
    for (int i = 0; i < max_ticks && done_cnt == d0; i++) run_tick();
    chk({nm, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_done_tick"}, 32'(done_at), 32'(exp_at));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    bus.i_start_n = 1'b1; bus.i_abort_n = 1'b1; bus.i_sample_tick_n = 1'b1;
    setup(4'd5, 1'b0, 4'd0, 2'd0, 32'h01000000, 32'h00100000);
    model_reset();
    repeat (3) cycle();
    chk("rst_acc", bus.o_phase_acc, 32'h0);
    chk("rst_inc", bus.o_phase_inc, 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    chk("rst_sym_n", 32'(bus.o_sym_start_n), 32'h1);
    chk("rst_done_n", 32'(bus.o_done_n), 32'h1);
    rst_n = 1'b1; chk_en = 1'b1;
    cycle();

    // 1: single up-chirp, SF=5
    start_seq();
    run_tick();
    chk("t1_acc_tick1", bus.o_phase_acc, 32'h01000000);
    chk("t1_inc_tick1", bus.o_phase_inc, 32'h01100000);
    run_until_done(64, "t1", 32);
    chk("t1_sym_pulses", 32'(sym_q.size()), 32'd1);
    cycle();

    // 2: up wrap past INC_MAX
    setup(4'd5, 1'b0, 4'd0, 2'd0, 32'h03300000, 32'h00100000);
    start_seq(); run_tick();
    chk("t2_inc_wrap", bus.o_phase_inc, 32'h000CCCCD);
    abort_seq();

    // 3: down underflow
    setup(4'd5, 1'b1, 4'd0, 2'd0, 32'h00080000, 32'h00100000);
    start_seq(); run_tick();
    chk("t3_inc_under", bus.o_phase_inc, 32'h032B3333);
    abort_seq();

    // 4: three chirps, phase continuous across boundaries
    setup(4'd5, 1'b0, 4'd2, 2'd2, 32'h00100000, 32'h00010000);
    start_seq();
    repeat (32) run_tick();
    chk("t4_acc_b1", bus.o_phase_acc, 32'h03F00000);
    chk("t4_inc_b1", bus.o_phase_inc, 32'h00100000);
    repeat (32) run_tick();
    chk("t4_acc_b2", bus.o_phase_acc, 32'h07E00000);
    chk("t4_inc_b2", bus.o_phase_inc, 32'h00100000);
    run_until_done(64, "t4", 96);
    chk("t4_sym_pulses", 32'(sym_q.size()), 32'd3);
    if (sym_q.size() == 3) begin
      chk("t4_sym0", 32'(sym_q[0]), 32'd0);
      chk("t4_sym1", 32'(sym_q[1]), 32'd32);
      chk("t4_sym2", 32'(sym_q[2]), 32'd64);
    end
    cycle();

    // 5: SF clamp, mid-run input changes ignored
    setup(4'd3, 1'b0, 4'd0, 2'd1, 32'h00200000, 32'h00300000);
    start_seq();
    repeat (5) run_tick();
    setup(4'd12, 1'b1, 4'd7, 2'd2, 32'h12345678, 32'h00000001);
    run_until_done(100, "t5_sf3", 32);
    cycle();
    setup(4'd15, 1'b1, 4'd0, 2'd0, 32'h00500000, 32'h00070000);
    start_seq();
    repeat (7) run_tick();
    bus.i_SF = 4'd5;
    run_until_done(5000, "t5_sf15", 4096);
    cycle();

    // 6: abort with simultaneous tick at tick 10
    setup(4'd5, 1'b0, 4'd0, 2'd0, 32'h01000000, 32'h00100000);
    d0 = done_cnt;
    start_seq();
    repeat (9) run_tick();
    bus.i_sample_tick_n = 1'b0; bus.i_abort_n = 1'b0; cycle();
    chk("t6_busy", 32'(bus.o_busy), 32'h0);
    bus.i_sample_tick_n = 1'b1; bus.i_abort_n = 1'b1; cycle();
    chk("t6_inc_held", bus.o_phase_inc, 32'h01900000);
    chk("t6_acc_held", bus.o_phase_acc, 32'h0B400000);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);

    // 6b: async reset mid-run
    start_seq();
    repeat (3) run_tick();
    #2 rst_n = 1'b0; model_reset();
    #1;
    chk("arst_acc", bus.o_phase_acc, 32'h0);
    chk("arst_inc", bus.o_phase_inc, 32'h0);
    chk("arst_busy", 32'(bus.o_busy), 32'h0);
    chk("arst_sym_n", 32'(bus.o_sym_start_n), 32'h1);
    chk("arst_done_n", 32'(bus.o_done_n), 32'h1);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
